// File: rtl/keypad_operand_entry_if.sv
// Key-event input and operand output bundle between the keypad reader,
// the operand entry block and the downstream arithmetic/display stages.
interface keypad_operand_entry_if #(
    parameter int W = 10
);
    logic         key_valid;
    logic [3:0]   key_code;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         ops_ready;
    logic [W-1:0] entry_val;
    logic [1:0]   digit_cnt;
    logic [1:0]   state;

    // master: the key source that consumes the results
    modport master (
        output key_valid, key_code,
        input  op_a, op_b, ops_ready, entry_val, digit_cnt, state
    );

    // slave: the operand entry block
    modport slave (
        input  key_valid, key_code,
        output op_a, op_b, ops_ready, entry_val, digit_cnt, state
    );
endinterface

// File: rtl/keypad_operand_entry.sv
// Assembles decoded keypad digits into two binary operands.
// 'A' closes operand A, '#' closes operand B and strobes ops_ready, '*' clears.
module keypad_operand_entry #(
    parameter int NDIG = 3,
    parameter int W    = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    keypad_operand_entry_if.slave   bus
);

    typedef enum logic [1:0] {
        ENTRY_A = 2'b00,
        ENTRY_B = 2'b01,
        DONE    = 2'b10,
        ILLEGAL = 2'b11
    } state_e;

    localparam logic [3:0] KEY_NEXT  = 4'hA;
    localparam logic [3:0] KEY_CLEAR = 4'hE;
    localparam logic [3:0] KEY_ENTER = 4'hF;

    state_e       state_q, state_d;
    logic [W-1:0] op_a_q, op_a_d;
    logic [W-1:0] op_b_q, op_b_d;
    logic [W-1:0] entry_val_q, entry_val_d;
    logic [1:0]   digit_cnt_q, digit_cnt_d;
    logic         ops_ready_q, ops_ready_d;

    logic         is_digit;
    logic         has_room;
    logic [W-1:0] acc_val;

    assign is_digit = (bus.key_code <= 4'd9);
    assign has_room = (int'(digit_cnt_q) < NDIG);
    // x*10 as (x<<3)+(x<<1); the W/NDIG rule guarantees no wrap
    assign acc_val  = (entry_val_q << 3) + (entry_val_q << 1) + W'(bus.key_code);

    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        entry_val_d = entry_val_q;
        digit_cnt_d = digit_cnt_q;
        ops_ready_d = 1'b0;

        if (state_q == ILLEGAL || (bus.key_valid && bus.key_code == KEY_CLEAR)) begin
            state_d     = ENTRY_A;
            op_a_d      = '0;
            op_b_d      = '0;
            entry_val_d = '0;
            digit_cnt_d = '0;
        end else if (bus.key_valid) begin
            case (state_q)
                ENTRY_A: begin
                    if (is_digit && has_room) begin
                        entry_val_d = acc_val;
                        digit_cnt_d = digit_cnt_q + 2'd1;
                    end else if (bus.key_code == KEY_NEXT) begin
                        op_a_d      = entry_val_q;
                        entry_val_d = '0;
                        digit_cnt_d = '0;
                        state_d     = ENTRY_B;
                    end
                end
                ENTRY_B: begin
                    if (is_digit && has_room) begin
                        entry_val_d = acc_val;
                        digit_cnt_d = digit_cnt_q + 2'd1;
                    end else if (bus.key_code == KEY_ENTER) begin
                        op_b_d      = entry_val_q;
                        entry_val_d = '0;
                        digit_cnt_d = '0;
                        ops_ready_d = 1'b1;
                        state_d     = DONE;
                    end
                end
                DONE: begin
                    // a digit here starts a fresh calculation and is kept
                    if (is_digit) begin
                        op_a_d      = '0;
                        op_b_d      = '0;
                        entry_val_d = W'(bus.key_code);
                        digit_cnt_d = 2'd1;
                        state_d     = ENTRY_A;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ENTRY_A;
            op_a_q      <= '0;
            op_b_q      <= '0;
            entry_val_q <= '0;
            digit_cnt_q <= '0;
            ops_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            entry_val_q <= entry_val_d;
            digit_cnt_q <= digit_cnt_d;
            ops_ready_q <= ops_ready_d;
        end
    end

    assign bus.op_a      = op_a_q;
    assign bus.op_b      = op_b_q;
    assign bus.entry_val = entry_val_q;
    assign bus.digit_cnt = digit_cnt_q;
    assign bus.state     = state_q;
    assign bus.ops_ready = ops_ready_q;

endmodule
